// File: rtl/float_type.sv
`default_nettype none
// ============================================================================
//  Module      : float_type (package)
//  Description : Shared floating-point types: single-precision layout,
//                operand classes, sequential-multiplier FSM states and
//                canonical quiet-NaN pattern generator.
//  Revision    : 1.1 - added fp_class_t, fp_mul_state_t and fp_qnan
// ============================================================================
package float_type;

    // Single-precision field layout used by the combinational product block
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } type_of_float;

    // Operand class after denormals-are-zero folding
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    // Sequential multiplier control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } fp_mul_state_t;

    // Canonical qNaN {0, all-ones exponent, 1, 0...}; callers slice the low
    // 1+exp_w+man_w bits. Formats up to 64 bits wide are supported.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Unpacks an IEEE-754 word into sign, exponent and significand
//                (hidden bit restored) and classifies it. Subnormals are
//                treated as zero (DAZ).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_sig,
    output fp_class_t            o_cls
);

    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_zero;

    // Field extraction and class decode
    always_comb begin
        o_sign     = i_op[EXP_W+MAN_W];
        o_exp      = i_op[EXP_W+MAN_W-1:MAN_W];
        w_exp_ones = &o_exp;
        w_exp_zero = ~|o_exp;
        w_man_zero = ~|i_op[MAN_W-1:0];
        o_sig      = {~w_exp_zero, i_op[MAN_W-1:0]};
        if (w_exp_ones) begin
            o_cls = w_man_zero ? INF : NAN;
        end else if (w_exp_zero) begin
            o_cls = ZERO;
        end else begin
            o_cls = NORMAL;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_seq
//  Description : Sequential shift-add IEEE-754 multiplier with generic widths,
//                valid/ready handshakes, round-to-nearest-even, DAZ/FTZ and
//                underflow/overflow/NaN/inexact flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_seq
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 flag_u,
    output logic                 flag_o,
    output logic                 flag_n,
    output logic                 flag_x
);

    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_N  = MAN_W + 1;
    localparam int c_PW = 2 * c_N;
    localparam int c_EW = EXP_W + 2;
    localparam int c_CW = $clog2(MAN_W + 1);

    localparam logic signed [c_EW-1:0] c_BIAS     = c_EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [c_EW-1:0] c_EXP_MAX  = c_EW'((2 ** EXP_W) - 1);
    localparam logic signed [c_EW-1:0] c_EXP_ONE  = c_EW'(1);
    localparam logic signed [c_EW-1:0] c_EXP_ZERO = c_EW'(0);
    localparam logic [63:0]            c_QNAN_ALL = fp_qnan(EXP_W, MAN_W);
    localparam logic [c_W-1:0]         c_QNAN     = c_QNAN_ALL[c_W-1:0];
    localparam logic [c_CW-1:0]        c_CNT_INIT = c_CW'(MAN_W);
    localparam logic [c_CW-1:0]        c_CNT_ONE  = c_CW'(1);

    fp_mul_state_t           r_state;
    logic [c_CW-1:0]         r_cnt;
    logic [c_N-1:0]          r_ma;
    logic [c_N-1:0]          r_mb;
    logic [c_PW-1:0]         r_acc;
    logic signed [c_EW-1:0]  r_exp;
    logic                    r_sign;
    logic [c_W-1:0]          r_result;
    logic                    r_flag_u;
    logic                    r_flag_o;
    logic                    r_flag_n;
    logic                    r_flag_x;
    logic                    r_out_valid;

    logic                    w_sign_a, w_sign_b;
    logic [EXP_W-1:0]        w_exp_a, w_exp_b;
    logic [MAN_W:0]          w_sig_a, w_sig_b;
    fp_class_t               w_cls_a, w_cls_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_op   (a),
        .o_sign (w_sign_a),
        .o_exp  (w_exp_a),
        .o_sig  (w_sig_a),
        .o_cls  (w_cls_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_op   (b),
        .o_sign (w_sign_b),
        .o_exp  (w_exp_b),
        .o_sig  (w_sig_b),
        .o_cls  (w_cls_b)
    );

    logic                    w_sign_p;
    logic                    w_is_nan;
    logic                    w_is_inf;
    logic                    w_is_zero;
    logic [c_W-1:0]          w_special_res;
    logic signed [c_EW-1:0]  w_exp_sum;

    // Special-case detection and biased exponent sum for the accepted pair
    always_comb begin
        w_sign_p  = w_sign_a ^ w_sign_b;
        w_is_nan  = (w_cls_a == NAN) || (w_cls_b == NAN) ||
                    ((w_cls_a == INF) && (w_cls_b == ZERO)) ||
                    ((w_cls_a == ZERO) && (w_cls_b == INF));
        w_is_inf  = !w_is_nan && ((w_cls_a == INF) || (w_cls_b == INF));
        w_is_zero = !w_is_nan && !w_is_inf && ((w_cls_a == ZERO) || (w_cls_b == ZERO));
        if (w_is_nan) begin
            w_special_res = c_QNAN;
        end else if (w_is_inf) begin
            w_special_res = {w_sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            w_special_res = {w_sign_p, {(c_W-1){1'b0}}};
        end
        w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - c_BIAS;
    end

    logic [MAN_W-1:0]        w_man;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_round_up;
    logic [MAN_W:0]          w_man_rnd;
    logic signed [c_EW-1:0]  w_exp_rnd;
    logic                    w_ovf;
    logic                    w_unf;

    // Round-to-nearest-even on the normalised product (leading 1 at the MSB)
    always_comb begin
        w_man      = r_acc[c_PW-2:MAN_W+1];
        w_guard    = r_acc[MAN_W];
        w_sticky   = |r_acc[MAN_W-1:0];
        w_round_up = w_guard & (w_sticky | w_man[0]);
        w_man_rnd  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_round_up};
        w_exp_rnd  = r_exp + (w_man_rnd[MAN_W] ? c_EXP_ONE : c_EXP_ZERO);
        w_ovf      = (w_exp_rnd >= c_EXP_MAX);
        w_unf      = (w_exp_rnd <= c_EXP_ZERO);
    end

    // Control FSM, shift-add iteration and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_result    <= '0;
            r_flag_u    <= 1'b0;
            r_flag_o    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_x    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign_p;
                        if (w_is_nan || w_is_inf || w_is_zero) begin
                            r_result <= w_special_res;
                            r_flag_u <= 1'b0;
                            r_flag_o <= 1'b0;
                            r_flag_n <= w_is_nan;
                            r_flag_x <= 1'b0;
                            r_state  <= DONE;
                        end else begin
                            r_ma    <= w_sig_a;
                            r_mb    <= w_sig_b;
                            r_acc   <= '0;
                            r_exp   <= w_exp_sum;
                            r_cnt   <= c_CNT_INIT;
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    // Multiplier bits are consumed MSB first
                    r_acc <= {r_acc[c_PW-2:0], 1'b0} +
                             (r_mb[c_N-1] ? {{c_N{1'b0}}, r_ma} : {c_PW{1'b0}});
                    r_mb  <= {r_mb[c_N-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state <= NORM;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                NORM: begin
                    if (r_acc[c_PW-1]) begin
                        r_exp <= r_exp + c_EXP_ONE;
                    end else begin
                        r_acc <= {r_acc[c_PW-2:0], 1'b0};
                    end
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_flag_n <= 1'b0;
                    if (w_ovf) begin
                        r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_flag_u <= 1'b0;
                        r_flag_o <= 1'b1;
                        r_flag_x <= 1'b1;
                    end else if (w_unf) begin
                        r_result <= {r_sign, {(c_W-1){1'b0}}};
                        r_flag_u <= 1'b1;
                        r_flag_o <= 1'b0;
                        r_flag_x <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
                        r_flag_u <= 1'b0;
                        r_flag_o <= 1'b0;
                        r_flag_x <= w_guard | w_sticky;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Special results arrive here with out_valid low; raise it one edge later
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_u    = r_flag_u;
    assign flag_o    = r_flag_o;
    assign flag_n    = r_flag_n;
    assign flag_x    = r_flag_x;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mul_seq
//  Description : Scoreboard bench for fp_mul_seq (FP32 instance plus a
//                half-precision instance) against an integer-arithmetic
//                reference model of IEEE-754 multiplication.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_seq;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flags;     // {u, o, n, x}
        int          lat;
        longint      acc_cyc;
    } exp_t;

    localparam logic [31:0] DIR_A [0:7] = '{32'h40400000, 32'hC0400000, 32'h7F800000, 32'hFF800000,
                                            32'h7F7FFFFF, 32'h00800000, 32'h3F800001, 32'h3FC00000};
    localparam logic [31:0] DIR_B [0:7] = '{32'h40200000, 32'h40200000, 32'h00000000, 32'h40000000,
                                            32'h40000000, 32'h00800000, 32'h3F800001, 32'h3FC00000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res32;
    logic        fu, fo, fn, fx;
    logic [3:0]  flags32;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] op_a16 = '0;
    logic [15:0] op_b16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] res16;
    logic        fu16, fo16, fn16, fx16;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc = 0;
    exp_t        sb_q[$];
    bit          or_force = 1'b0;
    bit          or_val = 1'b0;

    assign flags32 = {fu, fo, fn, fx};

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(op_a), .b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(res32), .flag_u(fu), .flag_o(fo), .flag_n(fn), .flag_x(fx)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(op_a16), .b(op_b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(res16), .flag_u(fu16), .flag_o(fo16), .flag_n(fn16), .flag_x(fx16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product, then RNE by remainder against half-ulp
    function automatic exp_t ref_mul(input logic [63:0] a, input logic [63:0] b,
                                     input int ew, input int mw);
        exp_t   r;
        longint emax, bias, mmask, ea, eb, ma, mb, p, q, rem, half, e;
        int     sh;
        bit     s, na, nb, ia, ib, za, zb;
        emax  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        mmask = (longint'(1) << mw) - 1;
        s     = a[ew+mw] ^ b[ew+mw];
        ea    = longint'(a >> mw) & emax;
        eb    = longint'(b >> mw) & emax;
        ma    = longint'(a) & mmask;
        mb    = longint'(b) & mmask;
        na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
        ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
        za = (ea == 0);                  zb = (eb == 0);
        r.flags = 4'b0000;
        r.lat   = 1;
        r.acc_cyc = 0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r.res   = 64'((emax << mw) | (longint'(1) << (mw - 1)));
            r.flags = 4'b0010;
        end else if (ia || ib) begin
            r.res = 64'((longint'(s) << (ew + mw)) | (emax << mw));
        end else if (za || zb) begin
            r.res = 64'(longint'(s) << (ew + mw));
        end else begin
            r.lat = mw + 3;
            p = (ma | (longint'(1) << mw)) * (mb | (longint'(1) << mw));
            e = ea + eb - bias;
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                e  = e + 1;
                sh = mw + 1;
            end else begin
                sh = mw;
            end
            q    = p >> sh;
            rem  = p & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                r.res   = 64'((longint'(s) << (ew + mw)) | (emax << mw));
                r.flags = 4'b0101;
            end else if (e <= 0) begin
                r.res   = 64'(longint'(s) << (ew + mw));
                r.flags = 4'b1001;
            end else begin
                r.res   = 64'((longint'(s) << (ew + mw)) | (e << mw) | (q & mmask));
                r.flags = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 15))
            0: begin e = 8'd0; if ($urandom_range(0, 1) == 0) m = '0; end
            1: e = 8'hFF;
            2: begin e = 8'hFF; m = '0; end
            3: e = 8'($urandom_range(190, 254));
            4: e = 8'($urandom_range(1, 64));
            5: begin e = 8'($urandom_range(120, 134)); m = 23'($urandom_range(0, 3)); end
            6: begin e = 8'($urandom_range(120, 134)); m = '1; end
            default: e = 8'($urandom_range(96, 158));
        endcase
        return {s, e, m};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present an operand pair and wait (bounded) for it to be accepted
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit track);
        exp_t e;
        int   waited;
        waited = 0;
        @(posedge clk); #1;
        op_a = ta; op_b = tb_; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) break;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", waited);
        end else if (track) begin
            e = ref_mul(64'(ta), 64'(tb_), 8, 23);
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Directed half-precision transaction on the second instance
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_);
        exp_t e;
        int   t;
        e = ref_mul(64'(ta), 64'(tb_), 5, 10);
        @(posedge clk); #1;
        op_a16 = ta; op_b16 = tb_; in_valid16 = 1'b1;
        @(negedge clk);
        chk("h_in_ready", 64'(in_ready16), 64'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        t = 0;
        while (!out_valid16 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("h_latency", 64'(t), 64'(e.lat));
        chk("h_result", 64'(res16), e.res);
        chk("h_flags", 64'({fu16, fo16, fn16, fx16}), 64'(e.flags));
        @(posedge clk);
    endtask

    // Consumer backpressure: random unless forced
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = or_force ? or_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on out_valid rise, hold while stalled, compare on handshake
    initial begin : monitor
        bit          prev_ov;
        bit          prev_hs;
        logic [31:0] prev_res;
        logic [3:0]  prev_fl;
        exp_t        e;
        prev_ov = 1'b0; prev_hs = 1'b0; prev_res = '0; prev_fl = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
                    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
                end
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: result %h with no operation outstanding", res32);
                    end else begin
                        chk("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
                    end
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                end
                if (out_valid && prev_ov && !prev_hs) begin
                    chk("hold_result", 64'(res32), 64'(prev_res));
                    chk("hold_flags", 64'(flags32), 64'(prev_fl));
                end
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("result", 64'(res32), e.res);
                    chk("flags", 64'(flags32), 64'(e.flags));
                end
                prev_hs  = out_valid && out_ready;
                prev_ov  = out_valid;
                prev_res = res32;
                prev_fl  = flags32;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "time budget exhausted");
    end

    initial begin : main
        int seen;
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(res32), 64'd0);
        chk("rst_flags", 64'(flags32), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_h_result", 64'(res16), 64'd0);

        run16(16'h4200, 16'h4100);
        run16(16'h7BFF, 16'h4000);
        run16(16'h3C01, 16'h3C01);
        run16(16'h7C00, 16'h0000);

        for (int i = 0; i < 8; i++) issue(DIR_A[i], DIR_B[i], 1'b1);
        for (int i = 0; i < 150; i++) issue(rand_op(), rand_op(), 1'b1);
        drain();

        // Stalled consumer with a second request pending
        or_force = 1'b1; or_val = 1'b0;
        issue(32'h40400000, 32'h40200000, 1'b1);
        op_a = 32'($urandom); op_b = 32'($urandom); in_valid = 1'b1;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        or_val = 1'b1;
        repeat (4) @(posedge clk);
        #1 or_force = 1'b0;
        drain();

        // Reset while multiplying discards the operation
        issue(32'h40400000, 32'h40200000, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_mid_no_output", 64'(seen), 64'd0);
        issue(32'h40400000, 32'h40200000, 1'b1);
        for (int i = 0; i < 20; i++) issue(rand_op(), rand_op(), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
